// File: rtl/mem_port_arbiter.sv
// Arbitrates the core and host ports onto one data-memory port: round-robin on
// conflict, fixed ISSUE/WAIT/RESP sequencing, and a bounded wait for mem_ready.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              c_err,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_ready,
  output logic              h_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic        GNT_CORE = 1'b0;
  localparam logic        GNT_HOST = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0]   h_rdata_q, h_rdata_d;
  logic                win;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_CORE;
      last_q    <= GNT_HOST;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      c_rdata_q <= c_rdata_d;
      h_rdata_q <= h_rdata_d;
    end
  end

  // Next-state logic: grant in IDLE, strobe in ISSUE, bounded wait, respond
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    timer_d   = timer_q;
    err_d     = err_q;
    c_rdata_d = c_rdata_q;
    h_rdata_d = h_rdata_q;
    win       = GNT_CORE;

    case (state_q)
      IDLE: begin
        if (c_req || h_req) begin
          // On conflict the requester that did not win last time goes first
          win     = (c_req && h_req) ? ~last_q : h_req;
          gnt_d   = win;
          we_d    = win ? h_we    : c_we;
          addr_d  = win ? h_addr  : c_addr;
          wdata_d = win ? h_wdata : c_wdata;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          if (!we_q) begin
            if (gnt_q == GNT_HOST) h_rdata_d = mem_rdata;
            else                   c_rdata_d = mem_rdata;
          end
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == ISSUE) &&  we_q;
  assign mem_re    = (state_q == ISSUE) && !we_q;
  assign c_ready   = (state_q == RESP) && (gnt_q == GNT_CORE);
  assign h_ready   = (state_q == RESP) && (gnt_q == GNT_HOST);
  assign c_err     = c_ready && err_q;
  assign h_err     = h_ready && err_q;
  assign c_rdata   = c_rdata_q;
  assign h_rdata   = h_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench: a transaction-level model predicts grant order,
// memory strobes, responses, latency and read data; a monitor checks the DUT.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, h_req, h_we;
  logic [AW-1:0] c_addr, h_addr, mem_addr;
  logic [DW-1:0] c_wdata, h_wdata, c_rdata, h_rdata, mem_wdata, mem_rdata;
  logic          c_ready, c_err, h_ready, h_err, mem_we, mem_re, mem_ready;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ready(c_ready), .c_err(c_err),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(h_rdata), .h_ready(h_ready), .h_err(h_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // lat: >=1 -> mem_ready that many cycles after the strobe; 0 -> timeout with a
  // late (ignored) mem_ready; -1 -> memory never answers
  typedef struct { bit host; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int lat; } txn_t;
  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } iss_t;
  typedef struct { bit host; bit err; logic [DW-1:0] c_rd; logic [DW-1:0] h_rd; int lat; } rsp_t;

  txn_t cq[$], hq[$];
  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   lat_q[$];
  int   rdy_cyc_q[$];

  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] tb_mem  [logic [AW-1:0]];
  logic [DW-1:0] m_rd [2];
  bit            m_last;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int strobe_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] dflt(logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm, string why);
    n_err++;
    $display("FAIL %s %s", nm, why);
  endtask

  function automatic txn_t mk(bit host, bit we, logic [AW-1:0] a, logic [DW-1:0] d, int lat);
    txn_t t;
    t.host = host; t.we = we; t.addr = a; t.wdata = d; t.lat = lat;
    return t;
  endfunction

  function automatic int rlat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return int'(TO);
    return int'($urandom_range(1, 3));
  endfunction

  function automatic txn_t rnd(bit host, int lat);
    return mk(host, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7) * 4), $urandom(), lat);
  endfunction

  // Reference model: serve both pending lists in arbitration order
  task automatic model_round();
    txn_t mc[$], mh[$];
    mc = cq;
    mh = hq;
    while (mc.size() > 0 || mh.size() > 0) begin
      bit   w;
      txn_t t;
      iss_t is;
      rsp_t rs;
      if (mc.size() > 0 && mh.size() > 0) w = !m_last;
      else                                w = (mh.size() > 0);
      if (w) t = mh.pop_front();
      else   t = mc.pop_front();
      is.we = t.we; is.addr = t.addr; is.wdata = t.wdata;
      iss_q.push_back(is);
      lat_q.push_back(t.lat);
      rs.host = w;
      rs.err  = (t.lat == 0);
      if (t.we) ref_mem[t.addr] = t.wdata;
      else if (!rs.err) m_rd[w] = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr);
      rs.c_rd = m_rd[0];
      rs.h_rd = m_rd[1];
      rs.lat  = rs.err ? int'(TO) + 1 : t.lat + 1;
      rsp_q.push_back(rs);
      m_last = w;
    end
  endtask

  task automatic drive_c();
    if (cq.size() > 0) begin
      c_req = 1'b1; c_we = cq[0].we; c_addr = cq[0].addr; c_wdata = cq[0].wdata;
    end else c_req = 1'b0;
  endtask

  task automatic drive_h();
    if (hq.size() > 0) begin
      h_req = 1'b1; h_we = hq[0].we; h_addr = hq[0].addr; h_wdata = hq[0].wdata;
    end else h_req = 1'b0;
  endtask

  // Each requester keeps req high while it has work and moves on at its ready
  task automatic run_round();
    int budget;
    budget = 0;
    model_round();
    drive_c();
    drive_h();
    while (cq.size() > 0 || hq.size() > 0) begin
      @(negedge clk);
      budget++;
      if (c_ready && cq.size() > 0) begin cq.delete(0); drive_c(); end
      if (h_ready && hq.size() > 0) begin hq.delete(0); drive_h(); end
      if (budget > 1000) begin
        fail("round_budget", "no ready within 1000 cycles");
        cq.delete(); hq.delete(); drive_c(); drive_h();
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_flags"}, 64'({c_ready, c_err, h_ready, h_err, mem_we, mem_re}), 64'd0);
    chk({nm, "_c_rdata"}, 64'(c_rdata), 64'd0);
    chk({nm, "_h_rdata"}, 64'(h_rdata), 64'd0);
    chk({nm, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({nm, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; c_req = 1'b0; h_req = 1'b0;
    #1 chk_zero("pulse_reset");
    @(negedge clk);
    reset = 1'b1;
    m_rd[0] = '0; m_rd[1] = '0; m_last = 1'b1;
  endtask

  // Memory device: commits writes at the strobe, answers after the scheduled delay
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = $urandom();
      if (reset && (mem_re || mem_we)) begin
        int            lat;
        logic [DW-1:0] rd;
        logic [AW-1:0] a;
        a   = mem_addr;
        lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
        if (mem_we) begin
          tb_mem[a] = mem_wdata;
          rd = $urandom();
        end else rd = tb_mem.exists(a) ? tb_mem[a] : dflt(a);
        if (lat >= 0) begin
          repeat ((lat == 0) ? int'(TO) + 1 : lat) @(negedge clk);
          mem_ready = 1'b1;
          mem_rdata = (lat == 0) ? 32'hBAD0_BAD0 : rd;
          @(negedge clk);
          mem_ready = 1'b0;
          mem_rdata = $urandom();
        end
      end
    end
  end

  // Monitor: compare strobes and responses against the scoreboard queues
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_re || mem_we) begin
          if (iss_q.size() == 0) fail("spurious_strobe", "strobe with nothing expected");
          else begin
            iss_t e;
            e = iss_q.pop_front();
            chk("strobe_kind", 64'({mem_we, mem_re}), e.we ? 64'd2 : 64'd1);
            chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
          end
          strobe_cyc = cyc;
        end
        if (c_ready || h_ready) begin
          if (rsp_q.size() == 0) fail("spurious_ready", "ready with nothing expected");
          else begin
            rsp_t r;
            r = rsp_q.pop_front();
            chk("single_ready", 64'(c_ready & h_ready), 64'd0);
            chk("ready_who", 64'(h_ready), 64'(r.host));
            chk("err", 64'(r.host ? h_err : c_err), 64'(r.err));
            chk("other_err", 64'(r.host ? c_err : h_err), 64'd0);
            chk("c_rdata", 64'(c_rdata), 64'(r.c_rd));
            chk("h_rdata", 64'(h_rdata), 64'(r.h_rd));
            chk("latency", 64'(cyc - strobe_cyc), 64'(r.lat));
          end
          rdy_cyc_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int b;
    iss_t is;
    reset = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    m_rd[0] = '0; m_rd[1] = '0; m_last = 1'b1;
    ref_mem[16'h0004] = 32'hDEAD_BEEF;
    tb_mem[16'h0004]  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;

    // Core read of 0x0004 answered one cycle after the strobe
    cq.push_back(mk(1'b0, 1'b0, 16'h0004, '0, 1));
    run_round();
    chk("core_read_data", 64'(c_rdata), 64'h0000_0000_DEAD_BEEF);

    // Host write leaves both rdata registers alone
    hq.push_back(mk(1'b1, 1'b1, 16'h0010, 32'h1234_5678, 2));
    run_round();
    chk("rdata_after_write", 64'(c_rdata), 64'h0000_0000_DEAD_BEEF);

    // Both requesters held high after reset: strict alternation, 4 cycles apart
    do_reset();
    rdy_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      cq.push_back(rnd(1'b0, 1));
      hq.push_back(rnd(1'b1, 1));
    end
    run_round();
    chk("alt_count", 64'(rdy_cyc_q.size()), 64'd8);
    for (int i = 1; i < rdy_cyc_q.size(); i++)
      chk("ready_spacing", 64'(rdy_cyc_q[i] - rdy_cyc_q[i-1]), 64'd4);

    // Timeout, then a normal read; mem_ready in the last WAIT cycle succeeds
    cq.push_back(mk(1'b0, 1'b0, 16'h0004, '0, 0));
    cq.push_back(mk(1'b0, 1'b0, 16'h0010, '0, 1));
    run_round();
    cq.push_back(mk(1'b0, 1'b0, 16'h0004, '0, int'(TO)));
    run_round();

    // Random mixes of pending work on both ports
    for (int r = 0; r < 40; r++) begin
      int nc, nh;
      nc = int'($urandom_range(0, 3));
      nh = int'($urandom_range(0, 3));
      if (nc + nh == 0) nc = 1;
      for (int i = 0; i < nc; i++) cq.push_back(rnd(1'b0, rlat()));
      for (int i = 0; i < nh; i++) hq.push_back(rnd(1'b1, rlat()));
      run_round();
    end

    // Reset while waiting for a memory that never answers
    is.we = 1'b0; is.addr = 16'h0008; is.wdata = '0;
    iss_q.push_back(is);
    lat_q.push_back(-1);
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0008;
    b = 0;
    while (!mem_re && b < 20) begin @(negedge clk); b++; end
    if (!mem_re) fail("mid_reset_strobe", "host read never issued");
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    h_req = 1'b0;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    chk("mid_reset_hold", 64'({c_ready, h_ready, mem_re, mem_we}), 64'd0);
    reset = 1'b1;
    m_rd[0] = '0; m_rd[1] = '0; m_last = 1'b1;
    hq.push_back(mk(1'b1, 1'b0, 16'h0010, '0, 1));
    run_round();

    repeat (5) @(negedge clk);
    chk("iss_q_drained", 64'(iss_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
